// File: rtl/ysyx_25030085_pc_pkg.sv
// Shared encodings for the PC generator: jump kinds, FSM states and the
// register indices that classify calls and returns.
package ysyx_25030085_pc_pkg;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_JAL  = 2'b01,
        JMP_JALR = 2'b10,
        JMP_RSVD = 2'b11
    } jump_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd1;

endpackage

// File: rtl/ysyx_25030085_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty leaves the stack unchanged.
module ysyx_25030085_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [XLEN-1:0]                push_data,
    output logic [XLEN-1:0]                top,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            mem_we;
    logic [PW-1:0]   mem_waddr;

    assign empty = (count_q == '0);
    assign count = count_q;
    assign top   = mem[wr_ptr_q - PTR_ONE];

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        if (push && pop) begin
            // Simultaneous pop+push replaces the top entry in place.
            mem_we    = 1'b1;
            mem_waddr = empty ? wr_ptr_q : wr_ptr_q - PTR_ONE;
            if (empty) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                count_d  = CNT_ONE;
            end
        end else if (push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (count_q != CNT_FULL) begin
                count_d = count_q + CNT_ONE;
            end
        end else if (pop && !empty) begin
            wr_ptr_d = wr_ptr_q - PTR_ONE;
            count_d  = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= push_data;
        end
    end

endmodule

// File: rtl/ysyx_25030085_pcgen.sv
// PC generator: FETCH/EXEC/HALT handshake with fetch, next-PC selection,
// misalignment redirect to mtvec, and call/return tracking through a RAS.
module ysyx_25030085_pcgen
    import ysyx_25030085_pc_pkg::*;
#(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = 32'h8000_0000,
    parameter int                RAS_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [XLEN-1:0]                   pc,
    output logic                              pc_valid,
    input  logic                              pc_ready,
    input  logic                              exu_done,
    input  logic [1:0]                        jump,
    input  logic                              branch_taken,
    input  logic [XLEN-1:0]                   imm,
    input  logic [XLEN-1:0]                   target,
    input  logic [4:0]                        rd,
    input  logic [4:0]                        rs1,
    input  logic                              is_ecall,
    input  logic                              is_mret,
    input  logic                              halt,
    input  logic [XLEN-1:0]                   mtvec,
    input  logic [XLEN-1:0]                   mepc,
    output logic                              misalign,
    output logic                              call_evt,
    output logic                              ret_evt,
    output logic [XLEN-1:0]                   evt_pc,
    output logic [XLEN-1:0]                   evt_dnpc,
    output logic                              ret_mismatch,
    output logic [$clog2(RAS_DEPTH+1)-1:0]    ras_count,
    output logic                              halted
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] evt_pc_q, evt_pc_d;
    logic [XLEN-1:0] evt_dnpc_q, evt_dnpc_d;
    logic            misalign_q, misalign_d;
    logic            call_evt_q, call_evt_d;
    logic            ret_evt_q, ret_evt_d;
    logic            ret_mismatch_q, ret_mismatch_d;

    jump_e           jump_eff;
    logic [XLEN-1:0] ret_target;
    logic [XLEN-1:0] sel_pc;
    logic            sel_misalign;
    logic            is_call;
    logic            is_ret;
    logic            retire;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    // Next-PC candidate and call/return classification of the executing instruction.
    always_comb begin
        jump_eff = jump_e'(jump);
        if (jump_eff == JMP_RSVD) begin
            jump_eff = JMP_NONE;
        end
        ret_target = target & ~XLEN'(1);
        if (is_ecall) begin
            sel_pc = mtvec;
        end else if (is_mret) begin
            sel_pc = mepc;
        end else if (jump_eff == JMP_JAL) begin
            sel_pc = pc_q + imm;
        end else if (jump_eff == JMP_JALR) begin
            sel_pc = ret_target;
        end else if (branch_taken) begin
            sel_pc = target;
        end else begin
            sel_pc = pc_q + XLEN'(4);
        end
        sel_misalign = (sel_pc[1:0] != 2'b00);
        is_call = !is_ecall && !is_mret && (jump_eff != JMP_NONE) && (rd == REG_RA);
        is_ret  = !is_ecall && !is_mret && (jump_eff == JMP_JALR) &&
                  (rd == REG_ZERO) && (rs1 == REG_RA);
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        evt_pc_d       = evt_pc_q;
        evt_dnpc_d     = evt_dnpc_q;
        misalign_d     = 1'b0;
        call_evt_d     = 1'b0;
        ret_evt_d      = 1'b0;
        ret_mismatch_d = 1'b0;
        retire         = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (pc_ready) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exu_done) begin
                    if (halt) begin
                        state_d = ST_HALT;
                    end else begin
                        retire         = 1'b1;
                        state_d        = ST_FETCH;
                        pc_d           = sel_misalign ? mtvec : sel_pc;
                        misalign_d     = sel_misalign;
                        call_evt_d     = is_call;
                        ret_evt_d      = is_ret;
                        ret_mismatch_d = is_ret && (ras_empty || (ras_top != ret_target));
                        if (is_call || is_ret) begin
                            evt_pc_d   = pc_q;
                            evt_dnpc_d = sel_pc;
                        end
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_PC;
            evt_pc_q       <= '0;
            evt_dnpc_q     <= '0;
            misalign_q     <= 1'b0;
            call_evt_q     <= 1'b0;
            ret_evt_q      <= 1'b0;
            ret_mismatch_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            evt_pc_q       <= evt_pc_d;
            evt_dnpc_q     <= evt_dnpc_d;
            misalign_q     <= misalign_d;
            call_evt_q     <= call_evt_d;
            ret_evt_q      <= ret_evt_d;
            ret_mismatch_q <= ret_mismatch_d;
        end
    end

    ysyx_25030085_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (retire && is_call),
        .pop       (retire && is_ret),
        .push_data (pc_q + XLEN'(4)),
        .top       (ras_top),
        .empty     (ras_empty),
        .count     (ras_count)
    );

    assign pc           = pc_q;
    assign pc_valid     = (state_q == ST_FETCH);
    assign halted       = (state_q == ST_HALT);
    assign misalign     = misalign_q;
    assign call_evt     = call_evt_q;
    assign ret_evt      = ret_evt_q;
    assign ret_mismatch = ret_mismatch_q;
    assign evt_pc       = evt_pc_q;
    assign evt_dnpc     = evt_dnpc_q;

endmodule

// File: tb/tb_ysyx_25030085_pcgen.sv
// Bench for the PC generator: directed vector table, hand-written multi-cycle
// sequences, and random instructions checked against a queue-based model.
module tb_ysyx_25030085_pcgen;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] MTVEC    = 32'h8000_0200;
    localparam logic [31:0] MEPC     = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        exu_done;
    logic [1:0]  jump;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] target;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        is_ecall;
    logic        is_mret;
    logic        halt;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        misalign;
    logic        call_evt;
    logic        ret_evt;
    logic [31:0] evt_pc;
    logic [31:0] evt_dnpc;
    logic        ret_mismatch;
    logic [3:0]  ras_count;
    logic        halted;

    always #5 clk = ~clk;

    ysyx_25030085_pcgen #(
        .XLEN      (XLEN),
        .RESET_PC  (RESET_PC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .exu_done     (exu_done),
        .jump         (jump),
        .branch_taken (branch_taken),
        .imm          (imm),
        .target       (target),
        .rd           (rd),
        .rs1          (rs1),
        .is_ecall     (is_ecall),
        .is_mret      (is_mret),
        .halt         (halt),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .misalign     (misalign),
        .call_evt     (call_evt),
        .ret_evt      (ret_evt),
        .evt_pc       (evt_pc),
        .evt_dnpc     (evt_dnpc),
        .ret_mismatch (ret_mismatch),
        .ras_count    (ras_count),
        .halted       (halted)
    );

    typedef struct {
        logic [1:0]  jump;
        logic        br;
        logic [31:0] imm;
        logic [31:0] target;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic        ecall;
        logic        mret;
        logic [31:0] mtvec;
        logic [31:0] mepc;
    } instr_t;

    typedef struct {
        logic [31:0] cur_pc;
        logic [31:0] nxt_pc;
        logic        mis;
        logic        call;
        logic        ret;
        logic        mm;
        logic [31:0] dnpc;
        int          count;
    } exp_t;

    typedef struct {
        instr_t in;
        exp_t   ex;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk_in(input logic [1:0] j, input logic br, input logic [31:0] im,
                                     input logic [31:0] tg, input logic [4:0] d, input logic [4:0] s,
                                     input logic ec, input logic mr);
        instr_t r;
        r.jump = j; r.br = br; r.imm = im; r.target = tg; r.rd = d; r.rs1 = s;
        r.ecall = ec; r.mret = mr; r.mtvec = MTVEC; r.mepc = MEPC;
        return r;
    endfunction

    function automatic exp_t mk_ex(input logic [31:0] cur, input logic [31:0] nxt, input logic mis,
                                   input logic cl, input logic rt, input logic mm,
                                   input logic [31:0] dn, input int cnt);
        exp_t r;
        r.cur_pc = cur; r.nxt_pc = nxt; r.mis = mis; r.call = cl; r.ret = rt; r.mm = mm;
        r.dnpc = dn; r.count = cnt;
        return r;
    endfunction

    // Reference model: next PC from the priority rules, RAS as a bounded queue.
    task automatic model_step(input instr_t in, output exp_t ex);
        logic [1:0]  j;
        logic [31:0] n;
        logic        c, r;
        j = (in.jump == 2'd3) ? 2'd0 : in.jump;
        if (in.ecall)        n = in.mtvec;
        else if (in.mret)    n = in.mepc;
        else if (j == 2'd1)  n = m_pc + in.imm;
        else if (j == 2'd2)  n = in.target - (in.target % 2);
        else if (in.br)      n = in.target;
        else                 n = m_pc + 32'd4;
        c = !in.ecall && !in.mret && (j != 2'd0) && (in.rd == 5'd1);
        r = !in.ecall && !in.mret && (j == 2'd2) && (in.rd == 5'd0) && (in.rs1 == 5'd1);
        ex.cur_pc = m_pc;
        ex.dnpc   = n;
        ex.mis    = (n % 4) != 0;
        ex.nxt_pc = ex.mis ? in.mtvec : n;
        ex.call   = c;
        ex.ret    = r;
        ex.mm     = r && ((m_ras.size() == 0) || (m_ras[m_ras.size()-1] != n));
        if (r && m_ras.size() > 0) void'(m_ras.pop_back());
        if (c) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        ex.count = m_ras.size();
        m_pc = ex.nxt_pc;
    endtask

    task automatic clear_inputs();
        exu_done = 1'b0; jump = 2'd0; branch_taken = 1'b0; imm = '0; target = '0;
        rd = '0; rs1 = '0; is_ecall = 1'b0; is_mret = 1'b0; halt = 1'b0;
        mtvec = MTVEC; mepc = MEPC;
    endtask

    task automatic drive_instr(input instr_t in);
        jump = in.jump; branch_taken = in.br; imm = in.imm; target = in.target;
        rd = in.rd; rs1 = in.rs1; is_ecall = in.ecall; is_mret = in.mret;
        mtvec = in.mtvec; mepc = in.mepc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        pc_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        m_pc = RESET_PC;
        m_ras.delete();
    endtask

    task automatic fetch_to_exec(input logic [31:0] cur);
        int n;
        n = $urandom_range(0, 2);
        pc_ready = 1'b0;
        repeat (n) step();
        chk("fetch_valid", pc_valid, 1'b1);
        chk("fetch_pc", pc, cur);
        pc_ready = 1'b1;
        step();
        pc_ready = 1'b0;
        chk("exec_valid_low", pc_valid, 1'b0);
    endtask

    task automatic do_instr(input instr_t in, input exp_t ex, input string tag);
        fetch_to_exec(ex.cur_pc);
        repeat ($urandom_range(0, 2)) step();
        drive_instr(in);
        exu_done = 1'b1;
        step();
        clear_inputs();
        chk({tag, "_pc"}, pc, ex.nxt_pc);
        chk({tag, "_misalign"}, misalign, ex.mis);
        chk({tag, "_call_evt"}, call_evt, ex.call);
        chk({tag, "_ret_evt"}, ret_evt, ex.ret);
        chk({tag, "_ret_mismatch"}, ret_mismatch, ex.mm);
        chk({tag, "_ras_count"}, ras_count, ex.count);
        chk({tag, "_halted"}, halted, 1'b0);
        if (ex.call || ex.ret) begin
            chk({tag, "_evt_pc"}, evt_pc, ex.cur_pc);
            chk({tag, "_evt_dnpc"}, evt_dnpc, ex.dnpc);
        end
        $display("txn %0d %s pc=%h next=%h mis=%0b call=%0b ret=%0b mm=%0b cnt=%0d",
                 txn, tag, ex.cur_pc, pc, misalign, call_evt, ret_evt, ret_mismatch, ras_count);
        txn++;
        step();
        chk({tag, "_pulses_clear"}, {misalign, call_evt, ret_evt, ret_mismatch}, 4'b0);
    endtask

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        instr_t      in;
        exp_t        ex;
        logic [31:0] addr[9];
        logic [31:0] cur;

        tbl[0]  = '{mk_in(2'd0, 0, 0, 0, 5'd0, 5'd0, 0, 0), mk_ex(32'h8000_0000, 32'h8000_0004, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{mk_in(2'd0, 0, 0, 0, 5'd0, 5'd0, 0, 0), mk_ex(32'h8000_0004, 32'h8000_0008, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{mk_in(2'd0, 0, 0, 0, 5'd0, 5'd0, 0, 0), mk_ex(32'h8000_0008, 32'h8000_000C, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{mk_in(2'd0, 0, 0, 0, 5'd0, 5'd0, 0, 0), mk_ex(32'h8000_000C, 32'h8000_0010, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{mk_in(2'd1, 0, 32'h100, 0, 5'd1, 5'd0, 0, 0),
                    mk_ex(32'h8000_0010, 32'h8000_0110, 0, 1, 0, 0, 32'h8000_0110, 1)};
        tbl[5]  = '{mk_in(2'd2, 0, 0, 32'h8000_0014, 5'd0, 5'd1, 0, 0),
                    mk_ex(32'h8000_0110, 32'h8000_0014, 0, 0, 1, 0, 32'h8000_0014, 0)};
        tbl[6]  = '{mk_in(2'd1, 0, 32'h100, 0, 5'd1, 5'd0, 1, 0), mk_ex(32'h8000_0014, 32'h8000_0200, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{mk_in(2'd0, 0, 0, 0, 5'd0, 5'd0, 0, 1), mk_ex(32'h8000_0200, 32'h8000_0014, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{mk_in(2'd0, 1, 0, 32'h8000_0006, 5'd0, 5'd0, 0, 0), mk_ex(32'h8000_0014, 32'h8000_0200, 1, 0, 0, 0, 0, 0)};
        tbl[9]  = '{mk_in(2'd3, 0, 32'h40, 0, 5'd1, 5'd0, 0, 0), mk_ex(32'h8000_0200, 32'h8000_0204, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{mk_in(2'd2, 0, 0, 32'h8000_0301, 5'd5, 5'd3, 0, 0), mk_ex(32'h8000_0204, 32'h8000_0300, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{mk_in(2'd2, 0, 0, 32'h8000_0400, 5'd0, 5'd1, 0, 0),
                    mk_ex(32'h8000_0300, 32'h8000_0400, 0, 0, 1, 1, 32'h8000_0400, 0)};

        do_reset();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_pc_valid", pc_valid, 1'b1);
        chk("rst_ras_count", ras_count, 0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pulses", {misalign, call_evt, ret_evt, ret_mismatch}, 4'b0);
        chk("rst_evt_pc", evt_pc, 0);
        chk("rst_evt_dnpc", evt_dnpc, 0);

        foreach (tbl[i]) do_instr(tbl[i].in, tbl[i].ex, $sformatf("vec%0d", i));

        // Halt: the EXEC instruction is not retired and everything freezes until reset.
        fetch_to_exec(32'h8000_0400);
        drive_instr(mk_in(2'd1, 0, 32'h100, 0, 5'd1, 5'd0, 0, 0));
        halt = 1'b1;
        exu_done = 1'b1;
        step();
        clear_inputs();
        chk("halt_halted", halted, 1'b1);
        chk("halt_pc", pc, 32'h8000_0400);
        chk("halt_call_evt", call_evt, 1'b0);
        chk("halt_ras_count", ras_count, 0);
        for (int c = 0; c < 100; c++) begin
            pc_ready = 1'($urandom_range(0, 1));
            exu_done = 1'($urandom_range(0, 1));
            jump = 2'($urandom_range(0, 3));
            rd = 5'd1;
            step();
            chk("halt_frozen", {pc_valid, halted, pc}, {1'b0, 1'b1, 32'h8000_0400});
        end
        $display("txn %0d halt pc=%h halted=%0b", txn, pc, halted);
        txn++;
        do_reset();
        chk("halt_rst_pc", pc, RESET_PC);
        chk("halt_rst_halted", halted, 1'b0);

        // Reset arriving together with exu_done discards the call.
        fetch_to_exec(RESET_PC);
        drive_instr(mk_in(2'd1, 0, 32'h100, 0, 5'd1, 5'd0, 0, 0));
        exu_done = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        chk("midrst_pc", pc, RESET_PC);
        chk("midrst_call_evt", call_evt, 1'b0);
        chk("midrst_ras_count", ras_count, 0);
        chk("midrst_valid", pc_valid, 1'b1);
        step();
        chk("midrst_after", {call_evt, ret_evt, ret_mismatch, misalign}, 4'b0);
        chk("midrst_evt_pc", evt_pc, 0);
        $display("txn %0d midexec_reset pc=%h", txn, pc);
        txn++;

        // Nine calls overflow the 8-entry stack; nine returns then run dry.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            cur = RESET_PC + 32'(k) * 32'h40;
            addr[k] = cur + 32'd4;
            do_instr(mk_in(2'd1, 0, 32'h40, 0, 5'd1, 5'd0, 0, 0),
                     mk_ex(cur, cur + 32'h40, 0, 1, 0, 0, cur + 32'h40, (k + 1 > DEPTH) ? DEPTH : k + 1),
                     $sformatf("call%0d", k));
        end
        cur = RESET_PC + 32'd9 * 32'h40;
        for (int r = 0; r < 9; r++) begin
            do_instr(mk_in(2'd2, 0, 0, addr[8-r], 5'd0, 5'd1, 0, 0),
                     mk_ex(cur, addr[8-r], 0, 0, 1, (r == 8), addr[8-r], (r < 8) ? 7 - r : 0),
                     $sformatf("ret%0d", r));
            cur = addr[8-r];
        end

        // Random instructions against the model.
        do_reset();
        for (int t = 0; t < 150; t++) begin
            in.jump   = 2'($urandom_range(0, 3));
            in.br     = 1'($urandom_range(0, 1));
            in.imm    = {$urandom_range(0, 32'hFFFF) , 16'h0} >> $urandom_range(0, 14);
            in.target = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            if ($urandom_range(0, 7) == 0) in.target[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) in.imm[1:0] = 2'($urandom_range(1, 3));
            in.rd     = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 1));
            in.rs1    = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
            in.ecall  = ($urandom_range(0, 9) == 0);
            in.mret   = ($urandom_range(0, 9) == 0);
            in.mtvec  = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            in.mepc   = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            if (in.jump == 2'd2 && m_ras.size() > 0 && $urandom_range(0, 1) == 1) begin
                in.target = m_ras[m_ras.size()-1];
            end
            model_step(in, ex);
            do_instr(in, ex, $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
